// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC, requests words from instruction memory,
// presents one instruction at a time to the core and commits the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc2,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        misaligned,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, READY, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        mis_q, mis_d;
  logic [31:0] next_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      instret_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    next_pc = pc_q + 32'd4;
    case (PCSrc2)
      2'b00:   next_pc = pc_q + 32'd4;
      2'b01:   next_pc = pc_q + ImmExt;
      default: next_pc = ALUResult & ~32'd1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    mis_d     = mis_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = READY;
        end
      end
      READY: begin
        if (advance) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
            state_d   = FETCH;
          end else begin
            mis_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // state sits at FETCH while reset is held, so the request is masked by reset
  assign imem_req    = (state_q == FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == READY);
  assign Instr       = instr_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign misaligned  = mis_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/advance sequences push the
// expected {PC, Instr, instret}; a monitor pops them on each entry to READY.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  PCSrc2;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        misaligned;
  logic [31:0] instret;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCSrc2(PCSrc2), .ImmExt(ImmExt),
    .ALUResult(ALUResult), .advance(advance), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .instr_valid(instr_valid),
    .misaligned(misaligned), .instret(instret)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instret;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got PC %h expected no instruction", PC);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_pc", PC, e.pc);
        chk("mon_instr", Instr, e.instr);
        chk("mon_instret", instret, e.instret);
        chk("mon_pcplus4", PCPlus4, e.pc + 32'd4);
      end
    end
    prev_valid = instr_valid;
  end

  // Called at a negedge in FETCH; leaves the DUT in READY at a negedge.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input int unsigned waits, input logic [31:0] exp_ret);
    exp_t e;
    e.pc = addr; e.instr = data; e.instret = exp_ret;
    q.push_back(e);
    for (int unsigned w = 0; w <= waits; w++) begin
      chk("fetch_req", {31'b0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, addr);
      imem_ack   = (w == waits);
      imem_rdata = (w == waits) ? data : 32'hFFFF_FFFF;
      @(negedge clk);
    end
    imem_ack = 1'b0;
  endtask

  task automatic do_advance(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    PCSrc2 = src; ImmExt = imm; ALUResult = alu; advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; advance = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    PCSrc2 = 2'b00; ImmExt = '0; ALUResult = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    reset = 1'b0;
    #1;

    do_fetch(32'h0, 32'h0050_0093, 3, 32'd0);
    do_advance(2'b00, '0, '0);
    chk("adv_req", {31'b0, imem_req}, 32'd1);
    chk("adv_pc", PC, 32'h4);
    chk("adv_instret", instret, 32'd1);
    do_fetch(32'h4, 32'h00a0_0113, 0, 32'd1);
    do_advance(2'b00, '0, '0);
    do_fetch(32'h8, 32'h0020_81b3, 0, 32'd2);
    do_advance(2'b01, 32'h0000_00F8, '0);
    do_fetch(32'h100, 32'h0040_006f, 0, 32'd3);
    do_advance(2'b01, 32'hFFFF_FFF0, '0);
    chk("branch_back_pc", PC, 32'h0000_00F0);
    do_fetch(32'hF0, 32'hfe00_08e3, 1, 32'd4);
    do_advance(2'b10, '0, 32'hFFFF_FFFD);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0073, 0, 32'd5);
    do_advance(2'b00, '0, '0);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_instret", instret, 32'd6);

    // advance while fetching is ignored
    PCSrc2 = 2'b01; ImmExt = 32'h40; advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    chk("ign_adv_pc", PC, 32'h0);
    chk("ign_adv_req", {31'b0, imem_req}, 32'd1);
    chk("ign_adv_instret", instret, 32'd6);
    do_fetch(32'h0, 32'h1357_9bdf, 2, 32'd6);

    // ack while ready is ignored
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("ign_ack_instr", Instr, 32'h1357_9bdf);
    chk("ign_ack_pc", PC, 32'h0);
    chk("ign_ack_valid", {31'b0, instr_valid}, 32'd1);
    chk("ign_ack_instret", instret, 32'd6);

    do_advance(2'b10, '0, 32'h205);
    chk("jalr_pc", PC, 32'h204);
    do_fetch(32'h204, 32'h0000_8067, 0, 32'd7);
    do_advance(2'b10, '0, 32'h206);
    PCSrc2 = 2'b00;
    for (int unsigned i = 0; i < 10; i++) begin
      chk("halt_req", {31'b0, imem_req}, 32'd0);
      chk("halt_valid", {31'b0, instr_valid}, 32'd0);
      chk("halt_mis", {31'b0, misaligned}, 32'd1);
      chk("halt_pc", PC, 32'h204);
      chk("halt_instret", instret, 32'd7);
      advance  = i[0];
      imem_ack = !i[0];
      @(negedge clk);
    end
    advance = 1'b0; imem_ack = 1'b0;

    reset = 1'b1;
    #1;
    chk("hrst_mis", {31'b0, misaligned}, 32'd0);
    chk("hrst_pc", PC, 32'h0);
    chk("hrst_req", {31'b0, imem_req}, 32'd0);
    chk("hrst_instret", instret, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    do_fetch(32'h0, 32'h0010_0513, 1, 32'd0);
    do_advance(2'b00, '0, '0);

    // reset while a fetch is pending; ack during reset must be dropped
    chk("pend_addr", imem_addr, 32'h4);
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("mrst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("mrst_instr", Instr, 32'h0000_0013);
    chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b0; reset = 1'b0;
    #1;
    chk("mrst_pc", PC, 32'h0);
    do_fetch(32'h0, 32'h0020_0593, 0, 32'd0);

    @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
